moving_avg_core: RTL
====================

// Module: moving_avg_core
//
// PURPOSE
//   Parametrised multi-lane moving-average engine for RFNoC computation engines.
//   Each accepted beat carries NCHAN signed lanes (e.g. I/Q). The block keeps a
//   running sum over the last LEN beats per lane, then scales it by
//   (SCALE >> SHIFT) using a multiplier instead of a divider IP core.
//   It sits between the AXI wrapper's m_axis_data and s_axis_data streams.
//   It replaces split/sum/divide/join chains with one backpressure-correct pipeline.
//
// PARAMETERS
//   WIDTH         16  signed sample width per lane
//   NCHAN         2   lanes per beat, packed lane 0 in LSBs
//   MAX_LEN_LOG2  8   history depth is 2**MAX_LEN_LOG2 beats
//   SCALE_W       16  unsigned scale multiplier width
//
// PORTS
//   ce_clk     in   1                  engine clock, all logic rising-edge
//   ce_rst_n   in   1                  async active-low reset
//   clear      in   1                  sync flush: pipeline, sum, fill count
//   len        in   MAX_LEN_LOG2+1     window length, 0 treated as 1, max 2**MAX_LEN_LOG2
//   scale      in   SCALE_W            unsigned multiplier
//   shift      in   5                  arithmetic right shift after multiply
//   i_tdata    in   NCHAN*WIDTH        input lanes
//   i_tlast    in   1                  input packet end
//   i_tvalid   in   1                  input valid
//   i_tready   out  1                  input ready
//   o_tdata    out  NCHAN*WIDTH        averaged lanes, saturated
//   o_tlast    out  1                  tlast of the corresponding input beat
//   o_tvalid   out  1                  output valid
//   o_tready   in   1                  output ready
//   o_sat      out  NCHAN              per-lane saturation flag, aligned to o_tdata
//
// BEHAVIOUR
//   - Reset: async assert, sync deassert. o_tvalid=0, o_tdata=0, o_tlast=0,
//     o_sat=0, i_tready=0 while ce_rst_n=0. Sums, write pointer and fill
//     count are 0. History RAM contents are don't-care.
//   - Pipeline: 4 stages, all gated by en = o_tready | ~o_tvalid.
//     i_tready = en & ~clear. Latency from accept to o_tvalid is 4 cycles
//     with no stall. Sustains 1 beat/cycle. No beat is dropped or duplicated.
//     tlast travels with its beat.
//   - S1: write the beat at wr_ptr. Synchronously read old = hist[wr_ptr - len]
//     (mod 2**MAX_LEN_LOG2), read-before-write. When len == depth the read
//     address equals wr_ptr and returns the evicted beat.
//     wr_ptr wraps at 2**MAX_LEN_LOG2.
//   - S2: per lane sum += new - (fill < len ? 0 : old). fill saturates at len.
//     Sum width is WIDTH+MAX_LEN_LOG2 (signed) and can never overflow.
//   - S3: prod = sum * $signed({1'b0,scale}). Width WIDTH+MAX_LEN_LOG2+SCALE_W+1.
//   - S4: res = prod >>> shift (floor), saturate to WIDTH signed. o_sat[k]=1
//     when lane k clipped to +2**(WIDTH-1)-1 or -2**(WIDTH-1).
//   - During fill, missing samples count as 0; an output is produced for
//     every input beat.
//   - clear (1 cycle): next edge zeroes sums, fill and wr_ptr, and invalidates
//     all in-flight stages (o_tvalid=0 next cycle, even if o_tready=0).
//     i_tready=0 during the clear cycle. clear together with i_tvalid: the beat
//     is not accepted.
//   - len/scale/shift are quasi-static. A len change without clear gives
//     undefined output until the next clear. scale/shift changes take effect on
//     the beat that reaches S3/S4 next.
//
// CONFIGURATION
//   MOVING_AVG_ROUND_EN defined: S4 adds 2**(shift-1) (only when shift>0)
//   before the shift, i.e. round-half-up, then saturates.
//   Undefined: pure truncation (floor). Latency is 4 in both builds.
//
// TESTING  (WIDTH=16, NCHAN=2, MAX_LEN_LOG2=8)
//   1 len=4,scale=1,shift=2; I=4,8,12,16,20, Q=-I -> I out 1,3,6,10,14;
//     Q out -1,-3,-6,-10,-14; latency 4.
//   2 len=4,scale=1,shift=2; I=3 x4 -> trunc 0,1,2,3; with
//     MOVING_AVG_ROUND_EN 1,2,2,3.
//   3 len=256,scale=2,shift=0; I=32767 stream -> out 32767 every beat, o_sat[0]=1
//     from beat 1. I=-32768 -> -32768, o_sat=1.
//   4 len=256,scale=1,shift=8; I=256 x600 -> from beat 256 onward out=256 each
//     beat (full-depth read-before-write wrap).
//   5 case 1 with o_tready random 33% low, tlast on beat 5 -> identical data
//     sequence, tlast only on 5th output, no drops.
//   6 clear at beat 3, then I=8 x4 (len=4,shift=2) -> in-flight outputs vanish;
//     out 2,4,6,8. ce_rst_n pulsed mid-stream -> o_tvalid=0 immediately,
//     same sequence after restart.

Source files
------------

// File: rtl/moving_avg_core.sv
// Multi-lane moving average: windowed running sum per lane, scaled by (scale >> shift), saturated.
// Define MOVING_AVG_ROUND_EN for round-half-up before the shift; otherwise the shift truncates (floor).
module moving_avg_core #(
    parameter int WIDTH        = 16,
    parameter int NCHAN        = 2,
    parameter int MAX_LEN_LOG2 = 8,
    parameter int SCALE_W      = 16
) (
    input  logic                   ce_clk,
    input  logic                   ce_rst_n,
    input  logic                   clear,
    input  logic [MAX_LEN_LOG2:0]  len,
    input  logic [SCALE_W-1:0]     scale,
    input  logic [4:0]             shift,
    input  logic [NCHAN*WIDTH-1:0] i_tdata,
    input  logic                   i_tlast,
    input  logic                   i_tvalid,
    output logic                   i_tready,
    output logic [NCHAN*WIDTH-1:0] o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic [NCHAN-1:0]       o_sat
);
    localparam int AW     = MAX_LEN_LOG2;
    localparam int DEPTH  = 1 << AW;
    localparam int SUM_W  = WIDTH + MAX_LEN_LOG2;
    localparam int PROD_W = SUM_W + SCALE_W + 1;
    localparam logic [AW:0] LEN_ONE = 1;
    localparam logic signed [PROD_W:0] SAT_MAX = {{(PROD_W+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PROD_W:0] SAT_MIN = {{(PROD_W+2-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};

    logic                   ready_q, ready_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]            fill_q, fill_d;
    logic [3:0]             vld_q, vld_d;
    logic [3:0]             last_q, last_d;
    logic [NCHAN*WIDTH-1:0] beat_q, beat_d;
    logic [NCHAN*WIDTH-1:0] old_q;
    logic [NCHAN*WIDTH-1:0] hist [DEPTH];

    logic          en, acc, sub_old;
    logic [AW:0]   len_eff;
    logic [AW-1:0] rd_addr;

    // Whole pipeline advances together; a stalled output freezes every stage.
    assign en       = o_tready | ~vld_q[3];
    assign i_tready = ready_q & en & ~clear;
    assign acc      = i_tvalid & i_tready;
    assign len_eff  = (len == '0) ? LEN_ONE : len;
    assign rd_addr  = wr_ptr_q - len_eff[AW-1:0];
    assign sub_old  = (fill_q >= len_eff);
    assign o_tvalid = vld_q[3];
    assign o_tlast  = last_q[3];

    // len == DEPTH reads the slot being overwritten; the old contents are returned.
    always_ff @(posedge ce_clk) begin
        if (acc) begin
            hist[wr_ptr_q] <= i_tdata;
            old_q          <= hist[rd_addr];
        end
    end

    always_comb begin
        ready_d  = 1'b1;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        vld_d    = vld_q;
        last_d   = last_q;
        beat_d   = beat_q;
        if (clear) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            vld_d    = '0;
        end else if (en) begin
            vld_d  = {vld_q[2:0], acc};
            last_d = {last_q[2:0], i_tlast};
            if (acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                beat_d   = i_tdata;
            end
            if (vld_q[0] && (fill_q < len_eff)) fill_d = fill_q + 1'b1;
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            ready_q  <= 1'b0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            vld_q    <= '0;
            last_q   <= '0;
            beat_q   <= '0;
        end else begin
            ready_q  <= ready_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
        end
    end

    genvar gi;
    for (gi = 0; gi < NCHAN; gi++) begin : g_lane
        logic signed [WIDTH-1:0]  beat_s, old_s, sub_s;
        logic signed [SUM_W-1:0]  sum_q, sum_d;
        logic signed [PROD_W-1:0] prod_q, prod_d;
        logic signed [PROD_W:0]   rnd, shifted;
        logic signed [WIDTH-1:0]  res_q, res_d;
        logic                     sat_q, sat_d;

        assign beat_s = beat_q[gi*WIDTH +: WIDTH];
        assign old_s  = old_q[gi*WIDTH +: WIDTH];

        always_comb begin
            sum_d  = sum_q;
            prod_d = prod_q;
            res_d  = res_q;
            sat_d  = sat_q;
            sub_s  = sub_old ? old_s : '0;
            rnd    = (PROD_W+1)'(prod_q);
`ifdef MOVING_AVG_ROUND_EN
            if (shift != 5'd0) rnd = rnd + ((PROD_W+1)'(1) << (shift - 5'd1));
`endif
            shifted = rnd >>> shift;
            if (clear) begin
                sum_d = '0;
            end else if (en) begin
                if (vld_q[0]) sum_d = sum_q + SUM_W'(beat_s) - SUM_W'(sub_s);
                if (vld_q[1]) prod_d = PROD_W'(sum_q) * PROD_W'($signed({1'b0, scale}));
                if (vld_q[2]) begin
                    if (shifted > SAT_MAX) begin
                        res_d = SAT_MAX[WIDTH-1:0];
                        sat_d = 1'b1;
                    end else if (shifted < SAT_MIN) begin
                        res_d = SAT_MIN[WIDTH-1:0];
                        sat_d = 1'b1;
                    end else begin
                        res_d = shifted[WIDTH-1:0];
                        sat_d = 1'b0;
                    end
                end
            end
        end

        always_ff @(posedge ce_clk or negedge ce_rst_n) begin
            if (!ce_rst_n) begin
                sum_q  <= '0;
                prod_q <= '0;
                res_q  <= '0;
                sat_q  <= 1'b0;
            end else begin
                sum_q  <= sum_d;
                prod_q <= prod_d;
                res_q  <= res_d;
                sat_q  <= sat_d;
            end
        end

        assign o_tdata[gi*WIDTH +: WIDTH] = res_q;
        assign o_sat[gi]                  = sat_q;
    end
endmodule
